alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor of the 1-bit ALU cell.
- Computes NOR, XOR, ADD or SUB on WIDTH-bit operands, BITS_PER_CYCLE bits per clock, LSB-first, with a registered carry between steps.
- Valid/ready handshakes on both sides; sits between the operand register file and the result writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 2.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- cin  input  1  carry-in, used by ADD only.
- op  input  2  00 NOR, 01 XOR, 10 ADD, 11 SUB (a-b).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- s  output  WIDTH  result.
- cout  output  1  carry out.
- zero, ovf  output  1 each  present only with ALU_SEQ_FLAGS_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, in_ready=1, out_valid=0, s=0, cout=0, zero=0, ovf=0; shift and carry registers cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid && in_ready:
  - latch a, b and op;
  - carry register loads cin for ADD, 1 for SUB, 0 otherwise;
  - step counter loads 0.
- RUN, each cycle:
  - alu_slice consumes the low BITS_PER_CYCLE bits of the a/b shift registers (b inverted for SUB);
  - the slice result is shifted into the top of the result register; the carry register is updated;
  - the counter increments.
- RUN -> DONE after N = WIDTH/BITS_PER_CYCLE RUN cycles. out_valid asserts the cycle after the last RUN cycle.
- Latency: out_valid rises N+1 cycles after the accepting edge (8+1 for default parameters).
- DONE holds s, cout and flags stable with out_valid=1 until out_ready=1.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A simultaneous handoff plus new accept goes DONE -> RUN directly, with no bubble.
- DONE with out_ready=1 and no new accept -> IDLE; out_valid drops next cycle.
- in_valid outside in_ready is ignored; operand inputs are don't-care outside the accept cycle.
- NOR/XOR: cout=0, ovf=0.
- ADD/SUB: cout = carry out of the MSB. For SUB, cout=1 means no borrow (a >= b unsigned).
- ovf = signed overflow: msb(a)==msb(b') && msb(s)!=msb(a), where b'=~b for SUB. Captured on the final RUN cycle.
- zero = (s==0), all ops.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the in-flight result is discarded and never presented.
- op is sampled only at accept; later changes have no effect.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined: zero and ovf ports and their registers exist, behaving as above.
- Undefined: ports and logic are absent. s and cout are unchanged, as are timing and handshakes.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_t enum: OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - alu_state_t enum: IDLE, RUN, DONE.
- Sub-module alu_slice: combinational, BITS_PER_CYCLE wide.
  - Inputs: a, b', cin, op.
  - Outputs: s, cout.
  - Its MSB-of-slice operand bits are exposed for the overflow check.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, BPC=1, ADD 0x7F+0x01, cin=0 -> s=0x80, cout=0, ovf=1, zero=0; out_valid exactly 9 cycles after accept.
- SUB 0x05-0x05 -> s=0x00, cout=1, zero=1, ovf=0. SUB 0x03-0x05 -> s=0xFE, cout=0.
- NOR 0xF0,0x0C -> s=0x03, cout=0. XOR 0xAA,0xFF -> s=0x55. ADD 0xFF+0x00 with cin=1 -> s=0x00, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> s and out_valid stable. Then out_ready=1 together with in_valid=1 -> new op accepted in the same cycle, next result after 9 cycles.
- Reset: rst_n low at RUN cycle 3 -> all outputs at reset values asynchronously; in_ready=1 after release; no stale out_valid.
- WIDTH=8, BPC=4, ADD 0xFF+0x01 -> s=0x00, cout=1, zero=1; out_valid 3 cycles after accept. Rebuild without ALU_SEQ_FLAGS_EN and confirm identical s/cout.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential bit-serial ALU (alu_seq) and its slice.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Carry seeded at accept: user cin for ADD, 1 for SUB (two's complement), else 0.
    function automatic logic init_carry(input alu_op_t op, input logic cin);
        logic c;
        c = 1'b0;
        if (op == OP_ADD)
            c = cin;
        else if (op == OP_SUB)
            c = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_slice.sv
// Combinational BITS_PER_CYCLE-wide ALU slice; b is already inverted for SUB.
// Optional ALU_SEQ_FLAGS_EN exposes the slice MSB operand bits for overflow.
module alu_slice
    import alu_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    input  logic                      cin,
    input  alu_op_t                   op,
    output logic [BITS_PER_CYCLE-1:0] s,
    output logic                      cout
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                      a_msb,
    output logic                      b_msb
`endif
);

    logic [BITS_PER_CYCLE:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{BITS_PER_CYCLE{1'b0}}, cin};
        s    = sum[BITS_PER_CYCLE-1:0];
        cout = sum[BITS_PER_CYCLE];
        case (op)
            OP_NOR: begin
                s    = ~(a | b);
                cout = 1'b0;
            end
            OP_XOR: begin
                s    = a ^ b;
                cout = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    assign a_msb = a[BITS_PER_CYCLE-1];
    assign b_msb = b[BITS_PER_CYCLE-1];
`endif

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle LSB-first ALU with valid/ready on both sides.
// Optional ALU_SEQ_FLAGS_EN adds the zero and ovf flag ports.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] FIN        = CW'(N);
    localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

    alu_state_t                state;
    alu_op_t                   op_q;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res_sh;
    logic                      carry;
    logic [CW-1:0]             cnt;

    logic [BITS_PER_CYCLE-1:0] bx;
    logic [BITS_PER_CYCLE-1:0] sl_s;
    logic                      sl_cout;
    logic [WIDTH-1:0]          sl_top;
    logic                      accept;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign bx       = (op_q == OP_SUB) ? ~b_sh[BITS_PER_CYCLE-1:0] : b_sh[BITS_PER_CYCLE-1:0];
    assign sl_top   = WIDTH'(sl_s) << (WIDTH - BITS_PER_CYCLE);

`ifdef ALU_SEQ_FLAGS_EN
    logic sl_a_msb;
    logic sl_b_msb;
    logic ovf_step;
    logic ovf_q;

    assign ovf_step = (op_q == OP_ADD || op_q == OP_SUB) &&
                      (sl_a_msb == sl_b_msb) && (sl_s[BITS_PER_CYCLE-1] != sl_a_msb);
`endif

    alu_slice #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_slice (
        .a    (a_sh[BITS_PER_CYCLE-1:0]),
        .b    (bx),
        .cin  (carry),
        .op   (op_q),
        .s    (sl_s),
        .cout (sl_cout)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .a_msb(sl_a_msb),
        .b_msb(sl_b_msb)
`endif
    );

    // RUN spends N slice cycles (cnt 0..N-1) plus one cycle at cnt==N that
    // publishes the result, giving out_valid N+1 cycles after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_NOR;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            ovf_q     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else if (accept) begin
            state     <= RUN;
            op_q      <= alu_op_t'(op);
            a_sh      <= a;
            b_sh      <= b;
            carry     <= init_carry(alu_op_t'(op), cin);
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt != FIN) begin
                        a_sh   <= a_sh >> BITS_PER_CYCLE;
                        b_sh   <= b_sh >> BITS_PER_CYCLE;
                        res_sh <= (res_sh >> BITS_PER_CYCLE) | sl_top;
                        carry  <= sl_cout;
                        cnt    <= cnt + CW'(1);
`ifdef ALU_SEQ_FLAGS_EN
                        if (cnt == LAST_SLICE)
                            ovf_q <= ovf_step;
`endif
                    end else begin
                        s         <= res_sh;
                        cout      <= carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef ALU_SEQ_FLAGS_EN
                        zero      <= (res_sh == '0);
                        ovf       <= ovf_q;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table + scoreboard on an 8/1 instance,
// plus hand sequences for latency, backpressure, reset and an 8/4 instance.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [1:0] op;
        logic [7:0] s;
        logic       cout;
        logic       zero;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, s;
    logic       cin, cout;
    logic [1:0] op;
    logic       zero, ovf;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0] a4, b4, s4;
    logic       cin4, cout4;
    logic [1:0] op4;
    logic       zero4, ovf4;

    int checks = 0;
    int errors = 0;

    vec_t sb_q[$];
    vec_t cur_exp;
    vec_t tbl[12];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout)
`ifdef ALU_SEQ_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    alu_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
        .s(s4), .cout(cout4)
`ifdef ALU_SEQ_FLAGS_EN
        , .zero(zero4), .ovf(ovf4)
`endif
    );

`ifndef ALU_SEQ_FLAGS_EN
    assign zero  = 1'b0;
    assign ovf   = 1'b0;
    assign zero4 = 1'b0;
    assign ovf4  = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                                input logic [1:0] vop, input logic [7:0] vs, input logic vco,
                                input logic vz, input logic vv);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.op = vop;
        v.s = vs; v.cout = vco; v.zero = vz; v.ovf = vv;
        return v;
    endfunction

    // Reference model from integer arithmetic, independent of the slice structure.
    function automatic vec_t model(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                                   input logic [1:0] vop);
        vec_t v;
        int   sd, ud;
        v = mk(va, vb, vc, vop, 8'h00, 1'b0, 1'b0, 1'b0);
        case (vop)
            2'b00: v.s = ~(va | vb);
            2'b01: v.s = va ^ vb;
            2'b10: begin
                ud = int'(va) + int'(vb) + int'(vc);
                sd = int'($signed(va)) + int'($signed(vb)) + int'(vc);
                v.s = ud[7:0];
                v.cout = (ud > 255);
                v.ovf = (sd > 127) || (sd < -128);
            end
            default: begin
                ud = int'(va) - int'(vb);
                sd = int'($signed(va)) - int'($signed(vb));
                v.s = ud[7:0];
                v.cout = (va >= vb);
                v.ovf = (sd > 127) || (sd < -128);
            end
        endcase
        v.zero = (v.s == 8'h00);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_result actual s=%0h required none", s);
                end else begin
                    vec_t e;
                    e = sb_q.pop_front();
                    check("sb_s", 32'(s), 32'(e.s));
                    check("sb_cout", 32'(cout), 32'(e.cout));
`ifdef ALU_SEQ_FLAGS_EN
                    check("sb_zero", 32'(zero), 32'(e.zero));
                    check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(cur_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_wait_in_ready", 32'(n), 32'(0));
        a = v.a; b = v.b; cin = v.cin; op = v.op;
        cur_exp = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 2'($urandom);
    endtask

    task automatic measure(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat, ov_seen;
        vec_t v;

        tbl[0]  = mk(8'h7F, 8'h01, 1'b0, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(8'h05, 8'h05, 1'b0, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(8'h03, 8'h05, 1'b0, 2'b11, 8'hFE, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(8'hF0, 8'h0C, 1'b0, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(8'hAA, 8'hFF, 1'b0, 2'b01, 8'h55, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(8'hFF, 8'h00, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0);
        tbl[6]  = mk(8'h80, 8'h80, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1);
        tbl[7]  = mk(8'h80, 8'h01, 1'b0, 2'b11, 8'h7F, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(8'h00, 8'h00, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(8'h3C, 8'h3C, 1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(8'h10, 8'h01, 1'b0, 2'b11, 8'h0F, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(8'h0F, 8'hF0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; op4 = '0;
        cur_exp = tbl[0];
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_s", 32'(s), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;
        tick();

        send(tbl[0]);
        measure(lat);
        check("latency_add", 32'(lat), 32'(9));
        drain();

        for (int i = 1; i < 12; i++) begin
            send(tbl[i]);
            drain();
        end

        // Back-to-back random traffic: DONE->RUN handoffs with no bubble.
        for (int i = 0; i < 20; i++)
            send(model(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom)));
        drain();

        // Backpressure, with in_valid held and garbage operands while not ready.
        out_ready = 1'b0;
        send(tbl[7]);
        measure(lat);
        check("latency_bp", 32'(lat), 32'(9));
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_s_hold", 32'(s), 32'(tbl[7].s));
            check("bp_cout_hold", 32'(cout), 32'(tbl[7].cout));
            check("bp_in_ready", 32'(in_ready), 32'(0));
            tick();
        end
        a = tbl[4].a; b = tbl[4].b; cin = tbl[4].cin; op = tbl[4].op;
        cur_exp = tbl[4];
        out_ready = 1'b1;
        #1;
        check("handoff_in_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        measure(lat);
        check("latency_handoff", 32'(lat), 32'(9));
        drain();

        // Reset in the middle of RUN discards the in-flight result.
        send(tbl[0]);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_s", 32'(s), 32'(0));
        check("midrst_cout", 32'(cout), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_zero", 32'(zero), 32'(0));
        check("midrst_ovf", 32'(ovf), 32'(0));
        tick();
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check("midrst_no_stale", 32'(ov_seen), 32'(0));
        check("midrst_ready_after", 32'(in_ready), 32'(1));
        send(tbl[1]);
        measure(lat);
        check("latency_after_rst", 32'(lat), 32'(9));
        drain();

        // 4 bits per cycle instance.
        a4 = 8'hFF; b4 = 8'h01; cin4 = 1'b0; op4 = 2'b10;
        check("bpc4_in_ready", 32'(in_ready4), 32'(1));
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        op4 = 2'b00;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        check("bpc4_latency", 32'(lat), 32'(3));
        check("bpc4_add_s", 32'(s4), 32'h00);
        check("bpc4_add_cout", 32'(cout4), 32'(1));
`ifdef ALU_SEQ_FLAGS_EN
        check("bpc4_add_zero", 32'(zero4), 32'(1));
        check("bpc4_add_ovf", 32'(ovf4), 32'(0));
`endif
        tick();
        v = model(8'h03, 8'h05, 1'b0, 2'b11);
        a4 = v.a; b4 = v.b; cin4 = v.cin; op4 = v.op;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        check("bpc4_sub_latency", 32'(lat), 32'(3));
        check("bpc4_sub_s", 32'(s4), 32'hFE);
        check("bpc4_sub_cout", 32'(cout4), 32'(0));
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
